dart_score_display: RTL

- Downstream consumer of the dart machine's score and status outputs.
- Snapshots both players' 9-bit point totals whenever a turn ends or the game is set.
- Converts both totals to BCD with an iterative shift-add-3 (double-dabble) engine.
- Drives a multiplexed 8-digit, active-low 7-segment display for the two scores plus a last-scorer indicator.

---
 rtl/dart_score_display.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dart_score_display.sv
`default_nettype none
// ============================================================================
// Module   : dart_score_display
// Brief    : Snapshots both players' point totals, converts them to BCD with
//            a shared-timing double-dabble engine and scans them onto an
//            8-digit active-low 7-segment display with a last-scorer digit.
//            Optional winner blink is enabled by defining DART_WIN_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dart_score_display #(
    parameter int SCAN_DIV  = 16,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] player_1_pt_i,
    input  logic [8:0] player_2_pt_i,
    input  logic       player_1_done_i,
    input  logic       player_2_done_i,
    input  logic       player_1_win_i,
    input  logic       player_2_win_i,
    input  logic       game_set_i,
    output logic [6:0] seg_o,
    output logic [7:0] an_o,
    output logic       busy_o
);

    localparam int         c_SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0] c_SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_load;
    logic          w_step;
    logic          w_commit;
    logic          w_request;

    logic          r_pending;
    logic          r_last_is_p2;   // 0 -> player 1 scored last, 1 -> player 2
    logic          r_game_over;
    logic [3:0]    r_shift_cnt;
    logic [20:0]   r_sr1;
    logic [20:0]   r_sr2;
    logic [3:0]    r_p1_h, r_p1_t, r_p1_o;
    logic [3:0]    r_p2_h, r_p2_t, r_p2_o;

    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic [2:0]          r_idx;
    logic                w_scan_wrap;
    logic [6:0]          w_seg_nxt;
    logic                w_blank_p1;
    logic                w_blank_p2;
    logic                w_show_p2;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
    function automatic logic [20:0] dabble_step(input logic [20:0] sr);
        logic [20:0] t;
        t = sr;
        for (int n = 0; n < 3; n++) begin
            if (t[9+4*n +: 4] >= 4'd5) begin
                t[9+4*n +: 4] = t[9+4*n +: 4] + 4'd3;
            end
        end
        return {t[19:0], 1'b0};
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return c_SEG_BLANK;
        endcase
    endfunction

    assign w_request = player_1_done_i | player_2_done_i | game_set_i;
    assign busy_o    = (r_state != S_IDLE);

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Conversion FSM next-state and datapath controls.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_step = 1'b1;
                if (r_shift_cnt == 4'd8) w_state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request bookkeeping: a new strobe always wins over the clear on launch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending    <= 1'b1;
            r_last_is_p2 <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            if (w_request)   r_pending <= 1'b1;
            else if (w_load) r_pending <= 1'b0;
            if (player_2_done_i)      r_last_is_p2 <= 1'b1;
            else if (player_1_done_i) r_last_is_p2 <= 1'b0;
            if (game_set_i) r_game_over <= 1'b1;
        end
    end

    // Shift registers and atomic commit into the display digit registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr1       <= '0;
            r_sr2       <= '0;
            r_shift_cnt <= '0;
            r_p1_h <= '0; r_p1_t <= '0; r_p1_o <= '0;
            r_p2_h <= '0; r_p2_t <= '0; r_p2_o <= '0;
        end else begin
            if (w_load) begin
                r_sr1       <= {12'd0, player_1_pt_i};
                r_sr2       <= {12'd0, player_2_pt_i};
                r_shift_cnt <= '0;
            end
            if (w_step) begin
                r_sr1       <= dabble_step(r_sr1);
                r_sr2       <= dabble_step(r_sr2);
                r_shift_cnt <= r_shift_cnt + 4'd1;
            end
            if (w_commit) begin
                r_p1_h <= r_sr1[20:17]; r_p1_t <= r_sr1[16:13]; r_p1_o <= r_sr1[12:9];
                r_p2_h <= r_sr2[20:17]; r_p2_t <= r_sr2[16:13]; r_p2_o <= r_sr2[12:9];
            end
        end
    end

    assign w_scan_wrap = (r_scan_cnt == c_SCAN_W'(SCAN_DIV - 1));

    // Digit slot timer and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (w_scan_wrap) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

`ifdef DART_WIN_BLINK_EN
    localparam int c_FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [c_FRAME_W-1:0] r_frame_cnt;
    logic                 r_blink_on;

    // Frame counter: toggles the blink phase every BLINK_DIV full scans.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_scan_wrap && (r_idx == 3'd7)) begin
            if (r_frame_cnt == c_FRAME_W'(BLINK_DIV - 1)) begin
                r_frame_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_blank_p1 = r_game_over & player_1_win_i & ~r_blink_on;
    assign w_blank_p2 = r_game_over & player_2_win_i & ~r_blink_on;
    assign w_show_p2  = (r_game_over & player_1_win_i) ? 1'b0 :
                        (r_game_over & player_2_win_i) ? 1'b1 : r_last_is_p2;
`else
    logic [3:0] w_unused;
    assign w_unused   = {player_1_win_i, player_2_win_i, r_game_over, (BLINK_DIV > 0)};
    assign w_blank_p1 = 1'b0;
    assign w_blank_p2 = 1'b0;
    assign w_show_p2  = r_last_is_p2;
`endif

    // Segment pattern for the digit currently selected by the scan index.
    always_comb begin
        w_seg_nxt = c_SEG_BLANK;
        case (r_idx)
            3'd0: w_seg_nxt = w_blank_p2 ? c_SEG_BLANK : seg7(r_p2_o);
            3'd1: w_seg_nxt = w_blank_p2 ? c_SEG_BLANK : seg7(r_p2_t);
            3'd2: w_seg_nxt = w_blank_p2 ? c_SEG_BLANK : seg7(r_p2_h);
            3'd3: w_seg_nxt = c_SEG_BLANK;
            3'd4: w_seg_nxt = w_blank_p1 ? c_SEG_BLANK : seg7(r_p1_o);
            3'd5: w_seg_nxt = w_blank_p1 ? c_SEG_BLANK : seg7(r_p1_t);
            3'd6: w_seg_nxt = w_blank_p1 ? c_SEG_BLANK : seg7(r_p1_h);
            3'd7: w_seg_nxt = seg7(w_show_p2 ? 4'd2 : 4'd1);
            default: w_seg_nxt = c_SEG_BLANK;
        endcase
    end

    // Segment and anode outputs registered together so they switch as a pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_o <= c_SEG_BLANK;
            an_o  <= 8'hFF;
        end else begin
            seg_o <= w_seg_nxt;
            an_o  <= ~(8'b1 << r_idx);
        end
    end

endmodule
`default_nettype wire
